// File: rtl/nec_ir_pkg.sv
// Shared NEC IR definitions: state encoding and timing constants in 50 MHz clock cycles.
// The receiver imports the same package so both ends agree on frame timing.
package nec_ir_pkg;

    localparam int LEAD_BURST_CYC   = 450000;
    localparam int LEAD_SPACE_CYC   = 225000;
    localparam int BIT_BURST_CYC    = 28000;
    localparam int ZERO_SPACE_CYC   = 28000;
    localparam int ONE_SPACE_CYC    = 84500;
    localparam int GAP_CYC          = 2000000;
    localparam int CARRIER_HALF_CYC = 658;

    localparam int CNT_W = 21;
    localparam int IDX_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_BURST,
        ST_LEAD_SPACE,
        ST_BIT_BURST,
        ST_BIT_SPACE,
        ST_STOP_BURST,
        ST_GAP
    } ir_state_e;

    function automatic logic is_mark(input ir_state_e s);
        return (s == ST_LEAD_BURST) || (s == ST_BIT_BURST) || (s == ST_STOP_BURST);
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier for the IR LED: square wave of period 2*HALF_CYC while en is high, restarting
// high on the first enabled cycle. en is the next-cycle mark flag so led lines up with ir_env.
module ir_carrier_gen #(
    parameter int HALF_CYC = nec_ir_pkg::CARRIER_HALF_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic led
);
    localparam int DIV_W = $clog2(HALF_CYC + 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             led_q, led_d;
    logic             en_q, en_d;

    always_comb begin
        en_d  = en;
        div_d = '0;
        led_d = 1'b0;
        if (en) begin
            if (!en_q) begin
                led_d = 1'b1;
            end else if (div_q == DIV_W'(HALF_CYC - 1)) begin
                led_d = ~led_q;
            end else begin
                div_d = div_q + 1'b1;
                led_d = led_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            led_q <= 1'b0;
            en_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            led_q <= led_d;
            en_q  <= en_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/nec_ir_transmit.sv
// NEC IR frame transmitter: leader, 32 pulse-distance bits LSB-first, stop mark, then idle gap.
// Define IR_TX_CARRIER_EN to modulate ir_led with the 38 kHz carrier; otherwise ir_led = ir_env.
module nec_ir_transmit #(
    parameter int LEAD_BURST_CYC = nec_ir_pkg::LEAD_BURST_CYC,
    parameter int LEAD_SPACE_CYC = nec_ir_pkg::LEAD_SPACE_CYC,
    parameter int BIT_BURST_CYC  = nec_ir_pkg::BIT_BURST_CYC,
    parameter int ZERO_SPACE_CYC = nec_ir_pkg::ZERO_SPACE_CYC,
    parameter int ONE_SPACE_CYC  = nec_ir_pkg::ONE_SPACE_CYC,
    parameter int GAP_CYC        = nec_ir_pkg::GAP_CYC
`ifdef IR_TX_CARRIER_EN
    , parameter int CARRIER_HALF_CYC = nec_ir_pkg::CARRIER_HALF_CYC
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid,
    input  logic [31:0] tx_data,
    output logic        tx_ready,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        ir_env,
    output logic        ir_out_n,
    output logic        ir_led
);
    import nec_ir_pkg::*;

    ir_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      shift_q, shift_d;
    logic             tx_ready_q, tx_ready_d;
    logic             tx_busy_q, tx_busy_d;
    logic             tx_done_q, tx_done_d;
    logic             ir_env_q, ir_env_d;
    logic             ir_out_n_q, ir_out_n_d;
    logic [CNT_W-1:0] seg_len;
    logic             seg_last;

    always_comb begin
        case (state_q)
            ST_LEAD_SPACE:               seg_len = CNT_W'(LEAD_SPACE_CYC);
            ST_BIT_BURST, ST_STOP_BURST: seg_len = CNT_W'(BIT_BURST_CYC);
            ST_BIT_SPACE:                seg_len = shift_q[0] ? CNT_W'(ONE_SPACE_CYC)
                                                              : CNT_W'(ZERO_SPACE_CYC);
            ST_GAP:                      seg_len = CNT_W'(GAP_CYC);
            default:                     seg_len = CNT_W'(LEAD_BURST_CYC);
        endcase
    end

    assign seg_last = (cnt_q == seg_len - 1'b1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // tx_ready is high exactly in IDLE, so tx_valid alone is the accept here
                if (tx_valid) begin
                    state_d = ST_LEAD_BURST;
                    shift_d = tx_data;
                    idx_d   = '0;
                end
            end
            ST_LEAD_BURST: if (seg_last) begin state_d = ST_LEAD_SPACE; cnt_d = '0; end
            ST_LEAD_SPACE: if (seg_last) begin state_d = ST_BIT_BURST;  cnt_d = '0; end
            ST_BIT_BURST:  if (seg_last) begin state_d = ST_BIT_SPACE;  cnt_d = '0; end
            ST_BIT_SPACE: begin
                if (seg_last) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_W'(31)) begin
                        state_d = ST_STOP_BURST;
                    end else begin
                        state_d = ST_BIT_BURST;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            ST_STOP_BURST: if (seg_last) begin state_d = ST_GAP;  cnt_d = '0; end
            ST_GAP:        if (seg_last) begin state_d = ST_IDLE; cnt_d = '0; end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        ir_env_d   = is_mark(state_d);
        ir_out_n_d = ~ir_env_d;
        tx_ready_d = (state_d == ST_IDLE);
        tx_busy_d  = (state_d != ST_IDLE);
        tx_done_d  = (state_d == ST_GAP) && (cnt_d == CNT_W'(GAP_CYC - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            ir_env_q   <= 1'b0;
            ir_out_n_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            tx_ready_q <= tx_ready_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
            ir_env_q   <= ir_env_d;
            ir_out_n_q <= ir_out_n_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign tx_busy  = tx_busy_q;
    assign tx_done  = tx_done_q;
    assign ir_env   = ir_env_q;
    assign ir_out_n = ir_out_n_q;

`ifdef IR_TX_CARRIER_EN
    ir_carrier_gen #(
        .HALF_CYC(CARRIER_HALF_CYC)
    ) u_carrier (
        .clk(clk),
        .rst(rst),
        .en (ir_env_d),
        .led(ir_led)
    );
`else
    assign ir_led = ir_env_q;
`endif

endmodule

// File: tb/tb_nec_ir_transmit.sv
// Scoreboard bench for nec_ir_transmit with shortened timing: the driver queues expected words,
// the monitor measures mark/space run lengths on ir_env, decodes each frame and compares.
module tb_nec_ir_transmit;
    localparam int LB  = 20;
    localparam int LS  = 10;
    localparam int BB  = 7;
    localparam int ZS  = 5;
    localparam int OS  = 12;
    localparam int GAP = 30;
`ifdef IR_TX_CARRIER_EN
    localparam int HALF = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_valid = 1'b0;
    logic [31:0] tx_data = '0;
    logic        tx_ready, tx_busy, tx_done, ir_env, ir_out_n, ir_led;

    nec_ir_transmit #(
        .LEAD_BURST_CYC(LB), .LEAD_SPACE_CYC(LS), .BIT_BURST_CYC(BB),
        .ZERO_SPACE_CYC(ZS), .ONE_SPACE_CYC(OS), .GAP_CYC(GAP)
`ifdef IR_TX_CARRIER_EN
        , .CARRIER_HALF_CYC(HALF)
`endif
    ) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done),
        .ir_env(ir_env), .ir_out_n(ir_out_n), .ir_led(ir_led)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] word;
        int          acc;
        bit          b2b;
    } exp_t;
    exp_t exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    bit in_frame  = 0;
    bit post_done = 0;
    bit cur_lvl   = 0;
    int run_len   = 0;
    int stop_end  = 0;
    int led_err   = 0;
    int outn_err  = 0;
    int busy_err  = 0;
    int segs[$];

    task automatic finish_frame();
        exp_t        e;
        logic [31:0] dec;
        int          total, mark_err, space_err, sp, want;
        chk("done_inside_frame", in_frame, 1);
        if (exp_q.size() == 0) begin
            chk("spurious_done", 1, 0);
        end else begin
            e = exp_q.pop_front();
            if (segs.size() != 67) begin
                chk("segment_count", segs.size(), 67);
            end else begin
                dec = '0; mark_err = 0; space_err = 0;
                total = LB + LS + 33 * BB;
                for (int i = 0; i < 32; i++) begin
                    want = e.word[i] ? OS : ZS;
                    total += want;
                    sp = segs[3 + 2 * i];
                    dec[i] = (sp == OS);
                    if (sp != want) space_err++;
                    if (segs[2 + 2 * i] != BB) mark_err++;
                end
                chk("lead_mark", segs[0], LB);
                chk("lead_space", segs[1], LS);
                chk("bit_mark_errors", mark_err, 0);
                chk("bit_space_errors", space_err, 0);
                chk("stop_mark", segs[66], BB);
                chk("decoded_word", dec, e.word);
                chk("frame_length", segs.sum(), total);
            end
            chk("gap_length", cur_lvl ? -1 : run_len, GAP);
            chk("led_errors", led_err, 0);
            chk("out_n_errors", outn_err, 0);
            chk("busy_errors", busy_err, 0);
        end
        led_err = 0; outn_err = 0; busy_err = 0;
        in_frame  = 0;
        post_done = 1;
    endtask

    initial begin
        bit led_req;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame  = 0;
                post_done = 0;
                continue;
            end
            if (post_done) begin
                chk("idle_ready_after_done", tx_ready, 1);
                chk("idle_busy_after_done", tx_busy, 0);
                chk("done_single_pulse", tx_done, 0);
                post_done = 0;
            end
            if (ir_out_n !== ~ir_env) outn_err++;
            if (!in_frame) begin
                if (ir_env) begin
                    in_frame = 1; cur_lvl = 1; run_len = 1;
                    segs.delete();
                    if (exp_q.size() == 0) begin
                        chk("spurious_frame", 1, 0);
                    end else begin
                        chk("start_latency", cyc - exp_q[0].acc, 0);
                        if (exp_q[0].b2b) chk("b2b_lead_offset", cyc - stop_end, GAP + 2);
                    end
                end
            end else begin
                if (ir_env == cur_lvl) begin
                    run_len++;
                end else begin
                    segs.push_back(run_len);
                    if (segs.size() == 67) stop_end = cyc - 1;
                    cur_lvl = ir_env;
                    run_len = 1;
                end
                if (!tx_busy || tx_ready) busy_err++;
            end
`ifdef IR_TX_CARRIER_EN
            led_req = (in_frame && ir_env) ? (((run_len - 1) / HALF) % 2 == 0) : 1'b0;
`else
            led_req = ir_env;
`endif
            if (ir_led !== led_req) led_err++;
            if (tx_done) finish_frame();
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [31:0] w, input bit keep, input bit b2b, input bit pulse);
        int t = 0;
        exp_t e;
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        while (!tx_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!tx_ready) begin
            chk("accept_timeout", 0, 1);
            tx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.word = w; e.acc = cyc; e.b2b = b2b;
        exp_q.push_back(e);
        $display("send word=0x%08h accept_cycle=%0d", w, cyc);
        tx_data = $urandom;
        if (!keep) tx_valid = 1'b0;
        if (pulse) begin
            repeat (100) begin
                @(posedge clk);
                #1;
                tx_valid = 1'($urandom_range(0, 1));
                tx_data  = $urandom;
            end
            tx_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tx_ready", tx_ready, 1);
        chk("reset_tx_busy", tx_busy, 0);
        chk("reset_tx_done", tx_done, 0);
        chk("reset_ir_env", ir_env, 0);
        chk("reset_ir_out_n", ir_out_n, 1);
        chk("reset_ir_led", ir_led, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        send(32'h0000_0000, 0, 0, 0);
        send(32'hFFFF_FFFF, 0, 0, 0);
        send(32'hE11E_00FF, 0, 0, 0);
        drain();

        // valid held high across two frames
        send($urandom, 1, 0, 0);
        send($urandom, 0, 1, 0);
        drain();

        // valid pulses while busy must not spawn a frame
        send($urandom, 0, 0, 1);
        drain();

        // abort mid-frame
        send($urandom, 0, 0, 0);
        repeat (150) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("abort_ir_env", ir_env, 0);
        chk("abort_tx_ready", tx_ready, 1);
        chk("abort_tx_busy", tx_busy, 0);
        chk("abort_tx_done", tx_done, 0);
        chk("abort_ir_out_n", ir_out_n, 1);
        chk("abort_ir_led", ir_led, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        send($urandom, 0, 0, 0);
        for (int i = 0; i < 6; i++) send($urandom, 0, 0, 1'($urandom_range(0, 1)));
        drain();

        repeat (GAP + 10) @(negedge clk);
        chk("final_idle_ready", tx_ready, 1);
        chk("final_idle_env", ir_env, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
